// File: rtl/ysyx_22041207_pipe_stage.sv
// ysyx_22041207_pipe_stage: two-entry skid-buffered pipeline register with flush,
// occupancy report and saturating stall counter.
module ysyx_22041207_pipe_stage #(
    parameter int PC_W   = 64,
    parameter int INST_W = 32,
    parameter int META_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [META_W-1:0] in_meta,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    output logic [META_W-1:0] out_meta,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);
    logic              main_valid, skid_valid;
    logic [INST_W-1:0] skid_inst;
    logic [PC_W-1:0]   skid_pc;
    logic [META_W-1:0] skid_meta;
    logic              accept, issue;

    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign accept    = in_valid & in_ready;
    assign issue     = main_valid & out_ready;
    assign occupancy = {main_valid & skid_valid, main_valid ^ skid_valid};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            out_inst   <= '0;
            out_pc     <= '0;
            out_meta   <= '0;
            skid_inst  <= '0;
            skid_pc    <= '0;
            skid_meta  <= '0;
            stall_cnt  <= '0;
        end else begin
            if (main_valid && !out_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            // payload registers keep their contents on flush and on bubbles
            if (flush) begin
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
            end else if (skid_valid) begin
                if (issue) begin
                    out_inst   <= skid_inst;
                    out_pc     <= skid_pc;
                    out_meta   <= skid_meta;
                    skid_valid <= 1'b0;
                end
            end else if (issue || !main_valid) begin
                main_valid <= accept;
                if (accept) begin
                    out_inst <= in_inst;
                    out_pc   <= in_pc;
                    out_meta <= in_meta;
                end
            end else if (accept) begin
                skid_inst  <= in_inst;
                skid_pc    <= in_pc;
                skid_meta  <= in_meta;
                skid_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_22041207_pipe_stage.sv
// tb_ysyx_22041207_pipe_stage: directed vector table plus queue-based reference model
// with random traffic; a CNT_W=4 twin shares the inputs to exercise counter saturation.
module tb_ysyx_22041207_pipe_stage;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic [3:0]  in_meta;
    logic        in_ready, out_valid;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    logic [3:0]  out_meta;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;
    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_inst;
    logic [63:0] s_out_pc;
    logic [3:0]  s_out_meta;
    logic [1:0]  s_occupancy;
    logic [3:0]  s_stall_cnt;

    always #5 clk = ~clk;

    ysyx_22041207_pipe_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .in_meta(in_meta), .out_valid(out_valid),
        .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc), .out_meta(out_meta),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    ysyx_22041207_pipe_stage #(.CNT_W(4)) sat (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .in_meta(in_meta), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_inst(s_out_inst), .out_pc(s_out_pc), .out_meta(s_out_meta),
        .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [3:0]  meta;
    } ent_t;

    typedef struct {
        logic        rn, fl, iv, ordy;
        logic [63:0] pc;
        logic        ov;
        logic [1:0]  occ;
        logic        ir;
        logic [63:0] opc;
        logic [31:0] oinst;
        logic [15:0] cnt;
    } vec_t;

    int    checks = 0;
    int    failures = 0;
    ent_t  mq[$];
    ent_t  last = '0;
    logic [15:0] m_cnt = '0;
    logic [3:0]  m_sat = '0;
    vec_t  tbl[22];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rn, fl, iv, ordy, input logic [63:0] pc,
                                input logic ov, input logic [1:0] occ, input logic ir,
                                input logic [63:0] opc, input logic [31:0] oinst,
                                input logic [15:0] cnt);
        vec_t v;
        v.rn = rn; v.fl = fl; v.iv = iv; v.ordy = ordy; v.pc = pc;
        v.ov = ov; v.occ = occ; v.ir = ir; v.opc = opc; v.oinst = oinst; v.cnt = cnt;
        return v;
    endfunction

    task automatic drv(input logic rn, fl, iv, ordy, input logic [63:0] pc,
                       input logic [31:0] inst, input logic [3:0] meta);
        rst_n = rn; flush = fl; in_valid = iv; out_ready = ordy;
        in_pc = pc; in_inst = inst; in_meta = meta;
    endtask

    // advance the reference model by one cycle, scoring every entry the DUT hands off
    task automatic tick();
        int   sz;
        ent_t e;
        if (!rst_n) begin
            mq.delete();
            m_cnt = '0;
            m_sat = '0;
            last  = '0;
        end else begin
            sz = mq.size();
            if (sz > 0 && !out_ready) begin
                if (m_cnt != 16'hFFFF) m_cnt++;
                if (m_sat != 4'hF) m_sat++;
            end
            if (sz > 0 && out_ready) begin
                e = mq.pop_front();
                chk("issue_pc", out_pc, e.pc);
                chk("issue_inst", {32'b0, out_inst}, {32'b0, e.inst});
                chk("issue_meta", {60'b0, out_meta}, {60'b0, e.meta});
            end
            if (flush) mq.delete();
            else if (in_valid && sz < 2) mq.push_back('{pc: in_pc, inst: in_inst, meta: in_meta});
            if (mq.size() > 0) last = mq[0];
        end
        @(posedge clk);
        #1;
        chk("out_valid", {63'b0, out_valid}, {63'b0, mq.size() > 0});
        chk("occupancy", {62'b0, occupancy}, 64'(mq.size()));
        chk("in_ready", {63'b0, in_ready}, {63'b0, mq.size() < 2});
        chk("held_pc", out_pc, last.pc);
        chk("held_inst", {32'b0, out_inst}, {32'b0, last.inst});
        chk("held_meta", {60'b0, out_meta}, {60'b0, last.meta});
        chk("stall_cnt", {48'b0, stall_cnt}, {48'b0, m_cnt});
        chk("sat_cnt", {60'b0, s_stall_cnt}, {60'b0, m_sat});
    endtask

    initial begin
        tbl[0]  = mk(0, 0, 1, 1, 64'h999,       0, 0, 1, 64'h0,        32'h0,        0);
        tbl[1]  = mk(1, 0, 1, 1, 64'h8000_0000, 1, 1, 1, 64'h8000_0000, 32'h8000_0013, 0);
        tbl[2]  = mk(1, 0, 1, 1, 64'h8000_0004, 1, 1, 1, 64'h8000_0004, 32'h8000_0017, 0);
        tbl[3]  = mk(1, 0, 1, 1, 64'h8000_0008, 1, 1, 1, 64'h8000_0008, 32'h8000_001B, 0);
        tbl[4]  = mk(1, 0, 0, 1, 64'h0,         0, 0, 1, 64'h8000_0008, 32'h8000_001B, 0);
        tbl[5]  = mk(1, 0, 1, 0, 64'h200,       1, 1, 1, 64'h200,      32'h213,      0);
        tbl[6]  = mk(1, 0, 1, 0, 64'h204,       1, 2, 0, 64'h200,      32'h213,      1);
        tbl[7]  = mk(1, 0, 1, 0, 64'h208,       1, 2, 0, 64'h200,      32'h213,      2);
        tbl[8]  = mk(1, 0, 1, 1, 64'h208,       1, 1, 1, 64'h204,      32'h217,      2);
        tbl[9]  = mk(1, 0, 1, 1, 64'h208,       1, 1, 1, 64'h208,      32'h21B,      2);
        tbl[10] = mk(1, 0, 0, 1, 64'h0,         0, 0, 1, 64'h208,      32'h21B,      2);
        tbl[11] = mk(1, 0, 1, 0, 64'h300,       1, 1, 1, 64'h300,      32'h313,      2);
        tbl[12] = mk(1, 0, 1, 0, 64'h304,       1, 2, 0, 64'h300,      32'h313,      3);
        tbl[13] = mk(1, 1, 1, 0, 64'h100,       0, 0, 1, 64'h300,      32'h313,      4);
        tbl[14] = mk(1, 0, 1, 1, 64'h400,       1, 1, 1, 64'h400,      32'h413,      4);
        tbl[15] = mk(1, 1, 1, 1, 64'h100,       0, 0, 1, 64'h400,      32'h413,      4);
        tbl[16] = mk(1, 0, 1, 1, 64'h0,         1, 1, 1, 64'h0,        32'h13,       4);
        tbl[17] = mk(1, 0, 0, 1, 64'h0,         0, 0, 1, 64'h0,        32'h13,       4);
        tbl[18] = mk(1, 0, 0, 0, 64'h0,         0, 0, 1, 64'h0,        32'h13,       4);
        tbl[19] = mk(1, 0, 1, 0, 64'h600,       1, 1, 1, 64'h600,      32'h613,      4);
        tbl[20] = mk(1, 0, 1, 0, 64'h604,       1, 2, 0, 64'h600,      32'h613,      5);
        tbl[21] = mk(0, 1, 1, 1, 64'h700,       0, 0, 1, 64'h0,        32'h0,        0);

        for (int i = 0; i < 22; i++) begin
            logic [63:0] p;
            p = tbl[i].pc;
            drv(tbl[i].rn, tbl[i].fl, tbl[i].iv, tbl[i].ordy, p, p[31:0] ^ 32'h13, p[5:2]);
            tick();
            chk($sformatf("vec%0d_valid", i), {63'b0, out_valid}, {63'b0, tbl[i].ov});
            chk($sformatf("vec%0d_occ", i), {62'b0, occupancy}, {62'b0, tbl[i].occ});
            chk($sformatf("vec%0d_ready", i), {63'b0, in_ready}, {63'b0, tbl[i].ir});
            chk($sformatf("vec%0d_pc", i), out_pc, tbl[i].opc);
            chk($sformatf("vec%0d_inst", i), {32'b0, out_inst}, {32'b0, tbl[i].oinst});
            chk($sformatf("vec%0d_cnt", i), {48'b0, stall_cnt}, {48'b0, tbl[i].cnt});
        end

        drv(1, 0, 1, 0, 64'h900, 32'h913, 4'h5);
        tick();
        drv(1, 0, 0, 0, 64'h0, 32'h0, 4'h0);
        for (int i = 0; i < 20; i++) tick();
        chk("saturated_cnt4", {60'b0, s_stall_cnt}, 64'hF);
        chk("stall_20", {48'b0, stall_cnt}, 64'd20);

        for (int i = 0; i < 600; i++) begin
            drv($urandom_range(0, 99) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 2) != 0, {32'($urandom), 32'($urandom)}, 32'($urandom),
                4'($urandom_range(0, 15)));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
